test_cmd_module: RTL and testbench
==================================

# test_cmd_module

Serial test-command decoder that sits directly downstream of the pin-sequence mode detector. Once test mode is enabled and the interface mode is resolved (`spi_en_s_val`), it frames 16-bit commands shifted in on `a2_wpbar` while `a0_csbar` is low. It decodes opcodes into trim and test-mux registers. It returns `test_disable` upstream to leave test mode.

## Interface
- `OSC_TRIM_DEF`, 6'd32, reset/default value of `trim_osc`
- `VREF_TRIM_DEF`, 5'd16, reset/default value of `trim_vref`
- `EXIT_OP`, 8'h0F, opcode that requests test-mode exit
- `mode_cfg_clk`  in  1  sole clock, all flops on rising edge
- `por_rst`  in  1  reset; synchronous, active-high
- `test_en`  in  1  test mode active (from mode detector)
- `spi_en_s_val`  in  1  interface mode resolved (from mode detector)
- `a0_csbar`  in  1  frame enable, active-low
- `a2_wpbar`  in  1  serial data, MSB first
- `ee_wbusy_comb`  in  1  EEPROM write busy
- `test_disable`  out  1  one-cycle pulse to mode detector
- `trim_osc`  out  6  oscillator trim
- `trim_vref`  out  5  reference trim
- `test_mux_sel`  out  4  analog test-mux select, 0 = off
- `cmd_done`  out  1  one-cycle pulse per executed command
- `cmd_err`  out  1  sticky error flag

## Operation
- Frame = opcode[7:0] then data[7:0], 16 bits, MSB first, one bit per `mode_cfg_clk` edge with `a0_csbar` low.
- FSM states: ARM, IDLE, SHIFT, EXEC, WAIT_CS. Reset state is ARM.
- Priority in every state: `por_rst` > `!test_en` > normal transitions.
- `!test_en` in any state: next state ARM, shift count cleared, `test_mux_sel` <= 0, `cmd_err` <= 0. Trims hold. A pending EXEC is not committed.
- ARM: wait for `a0_csbar`=1, then go to IDLE. This discards the tail of the enabling sequence frame.
- IDLE: when `test_en & spi_en_s_val & !a0_csbar`, sample `a2_wpbar` as bit 15, set count=1, go to SHIFT.
- SHIFT: each edge with `a0_csbar`=0 shifts in one bit and increments count.
  - After the 16th bit, go to EXEC.
  - `a0_csbar`=1 mid-frame aborts: partial frame discarded, go to IDLE, no error.
- EXEC is one cycle. Decode the frame:
  - 8'h01: `trim_osc` <= data[5:0].
  - 8'h02: `trim_vref` <= data[4:0].
  - 8'h03: `test_mux_sel` <= data[3:0].
  - `EXIT_OP`: `test_disable` pulse. Data is ignored.
  - Any other opcode: no register change, `cmd_err` <= 1.
  - Opcodes 01/02/03 with `ee_wbusy_comb`=1 during EXEC: rejected, registers unchanged, `cmd_err` <= 1.
  - `EXIT_OP` is never blocked by busy.
  - `cmd_done` pulses for every EXEC, including rejected ones. Next state is WAIT_CS.
- WAIT_CS: wait for `a0_csbar`=1, then go to IDLE. Bits clocked during WAIT_CS are ignored; one frame per CS-low window.
- `cmd_err` is cleared only by reset or by `!test_en`.

## Timing
- Reset values (synchronous, `por_rst`=1 at an edge):
  - `test_disable`=0, `cmd_done`=0, `cmd_err`=0.
  - `trim_osc`=`OSC_TRIM_DEF`, `trim_vref`=`VREF_TRIM_DEF`, `test_mux_sel`=0.
  - State ARM, shift register 0.
- First frame bit is sampled at edge E0; the last bit is sampled at edge E15; the FSM is in EXEC during the cycle E15..E16.
- At edge E16, register writes, `test_disable`, `cmd_done` and `cmd_err` become visible. This is 1 cycle of latency after the last bit.
- `test_disable` and `cmd_done` are high for exactly one cycle (E16..E17).
- After the exit command, upstream clears `test_en` at E17. This block then enters ARM at E18 and clears `test_mux_sel`.
- `a0_csbar` rising at the same edge as the 16th bit: the bit is not sampled and the frame is aborted.
- `test_en` falling during EXEC: no commit, no `cmd_done`.

## Test plan
- Reset mid-SHIFT (after 9 bits) → all outputs at reset values next cycle; state ARM; a following full frame is decoded correctly only after a CS-high period.
- `test_en`=1, `spi_en_s_val`=1, CS high then low, frame 0x01,0x2A → `trim_osc`=6'h2A at E16; `cmd_done` pulse at E16 only; `cmd_err`=0.
- Frame 0x03,0x05, then a second CS window with 0x0F,0x00 → `test_mux_sel`=4'h5; `test_disable` 1-cycle pulse; on `test_en` drop, `test_mux_sel`=0 and `trim_osc` held.
- Frame 0x02,0x1F with `ee_wbusy_comb`=1 in EXEC → `trim_vref` stays 5'd16; `cmd_err`=1; `cmd_done` pulse. A repeat with busy=0 → `trim_vref`=5'h1F; `cmd_err` stays 1.
- CS raised after 10 bits, then a full frame 0x01,0x07 → first frame discarded, `trim_osc`=6'h07, no error. Opcode 0x55 → `cmd_err`=1, no register change.
- 20 bits clocked in one CS-low window carrying 0x01,0x11,… → only the first 16 bits take effect (`trim_osc`=6'h11); the extra bits are ignored.

Source files
------------

// File: rtl/test_cmd_module.sv
// test_cmd_module
//   Serial test-command decoder downstream of the pin-sequence mode detector.
//   Frames 16-bit commands (opcode[7:0] then data[7:0], MSB first) shifted in
//   on a2_wpbar while a0_csbar is low, and decodes them into trim and
//   test-mux registers. The exit opcode pulses test_disable upstream.
//
// Ports
//   mode_cfg_clk   in   sole clock, rising edge
//   por_rst        in   synchronous active-high reset
//   test_en        in   test mode active (from mode detector)
//   spi_en_s_val   in   interface mode resolved (from mode detector)
//   a0_csbar       in   frame enable, active-low
//   a2_wpbar       in   serial data, MSB first
//   ee_wbusy_comb  in   EEPROM write busy
//   test_disable   out  one-cycle pulse requesting test-mode exit
//   trim_osc       out  oscillator trim
//   trim_vref      out  reference trim
//   test_mux_sel   out  analog test-mux select, 0 = off
//   cmd_done       out  one-cycle pulse per executed command
//   cmd_err        out  sticky error flag
module test_cmd_module #(
  parameter logic [5:0] OSC_TRIM_DEF  = 6'd32,
  parameter logic [4:0] VREF_TRIM_DEF = 5'd16,
  parameter logic [7:0] EXIT_OP       = 8'h0F
) (
  input  logic       mode_cfg_clk,
  input  logic       por_rst,
  input  logic       test_en,
  input  logic       spi_en_s_val,
  input  logic       a0_csbar,
  input  logic       a2_wpbar,
  input  logic       ee_wbusy_comb,
  output logic       test_disable,
  output logic [5:0] trim_osc,
  output logic [4:0] trim_vref,
  output logic [3:0] test_mux_sel,
  output logic       cmd_done,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    SHIFT,
    EXEC,
    WAIT_CS
  } state_t;

  state_t      state;
  logic [15:0] shreg;
  logic [3:0]  bit_cnt;

  always_ff @(posedge mode_cfg_clk) begin
    if (por_rst) begin
      state        <= ARM;
      shreg        <= '0;
      bit_cnt      <= '0;
      test_disable <= 1'b0;
      cmd_done     <= 1'b0;
      cmd_err      <= 1'b0;
      trim_osc     <= OSC_TRIM_DEF;
      trim_vref    <= VREF_TRIM_DEF;
      test_mux_sel <= '0;
    end else begin
      test_disable <= 1'b0;
      cmd_done     <= 1'b0;
      if (!test_en) begin
        // Leaving test mode drops any pending EXEC; trims are kept.
        state        <= ARM;
        bit_cnt      <= '0;
        test_mux_sel <= '0;
        cmd_err      <= 1'b0;
      end else begin
        case (state)
          ARM: begin
            // Swallow the rest of the enabling frame until CS goes high.
            if (a0_csbar) state <= IDLE;
          end
          IDLE: begin
            if (spi_en_s_val && !a0_csbar) begin
              shreg   <= {shreg[14:0], a2_wpbar};
              bit_cnt <= 4'd1;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (a0_csbar) begin
              // Mid-frame CS release: discard silently.
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              shreg <= {shreg[14:0], a2_wpbar};
              if (bit_cnt == 4'd15) begin
                bit_cnt <= '0;
                state   <= EXEC;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          EXEC: begin
            cmd_done <= 1'b1;
            state    <= WAIT_CS;
            if (shreg[15:8] == EXIT_OP) begin
              test_disable <= 1'b1;
            end else begin
              case (shreg[15:8])
                8'h01: begin
                  if (ee_wbusy_comb) cmd_err <= 1'b1;
                  else               trim_osc <= shreg[5:0];
                end
                8'h02: begin
                  if (ee_wbusy_comb) cmd_err <= 1'b1;
                  else               trim_vref <= shreg[4:0];
                end
                8'h03: begin
                  if (ee_wbusy_comb) cmd_err <= 1'b1;
                  else               test_mux_sel <= shreg[3:0];
                end
                default: cmd_err <= 1'b1;
              endcase
            end
          end
          WAIT_CS: begin
            if (a0_csbar) state <= IDLE;
          end
          default: state <= ARM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test_cmd_module.sv
module tb_test_cmd_module;

  logic       mode_cfg_clk = 1'b0;
  logic       por_rst;
  logic       test_en;
  logic       spi_en_s_val;
  logic       a0_csbar;
  logic       a2_wpbar;
  logic       ee_wbusy_comb;
  logic       test_disable;
  logic [5:0] trim_osc;
  logic [4:0] trim_vref;
  logic [3:0] test_mux_sel;
  logic       cmd_done;
  logic       cmd_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  test_cmd_module #(
    .OSC_TRIM_DEF (6'd32),
    .VREF_TRIM_DEF(5'd16),
    .EXIT_OP      (8'h0F)
  ) dut (
    .mode_cfg_clk (mode_cfg_clk),
    .por_rst      (por_rst),
    .test_en      (test_en),
    .spi_en_s_val (spi_en_s_val),
    .a0_csbar     (a0_csbar),
    .a2_wpbar     (a2_wpbar),
    .ee_wbusy_comb(ee_wbusy_comb),
    .test_disable (test_disable),
    .trim_osc     (trim_osc),
    .trim_vref    (trim_vref),
    .test_mux_sel (test_mux_sel),
    .cmd_done     (cmd_done),
    .cmd_err      (cmd_err)
  );

  always #5 mode_cfg_clk = ~mode_cfg_clk;

  // Advance one edge; inputs set after return are sampled at the next edge.
  task automatic tick();
    @(posedge mode_cfg_clk);
    #1;
  endtask

  // Clock n bits of w (MSB first) with CS low.
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      a0_csbar = 1'b0;
      a2_wpbar = w[i];
      tick();
    end
  endtask

  // Full frame; on return the edge E16 has just passed.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] dat, input logic busy);
    shift_bits({16'h0, op, dat}, 16);
    ee_wbusy_comb = busy;
    tick();
    ee_wbusy_comb = 1'b0;
  endtask

  task automatic cs_high();
    a0_csbar = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    por_rst = 1'b1; test_en = 1'b0; spi_en_s_val = 1'b0;
    a0_csbar = 1'b1; a2_wpbar = 1'b0; ee_wbusy_comb = 1'b0;
    tick(); tick();
    por_rst = 1'b0;
    tick();
    tests++; if (trim_osc !== 6'd32) begin fails++; $display("FAIL rst_osc got %0d exp 32", trim_osc); end
    tests++; if (trim_vref !== 5'd16) begin fails++; $display("FAIL rst_vref got %0d exp 16", trim_vref); end
    tests++; if (test_mux_sel !== 4'd0) begin fails++; $display("FAIL rst_mux got %0d exp 0", test_mux_sel); end
    tests++; if ({test_disable, cmd_done, cmd_err} !== 3'b000) begin
      fails++; $display("FAIL rst_flags got %b exp 000", {test_disable, cmd_done, cmd_err});
    end
  endtask

  task automatic test_trim_osc();
    test_en = 1'b1; spi_en_s_val = 1'b1;
    cs_high();
    shift_bits(32'h012A, 16);
    // In EXEC: nothing visible yet.
    tests++; if (cmd_done !== 1'b0 || trim_osc !== 6'd32) begin
      fails++; $display("FAIL osc_latency got done=%b osc=%h exp done=0 osc=20", cmd_done, trim_osc);
    end
    tick();
    tests++; if (trim_osc !== 6'h2A) begin fails++; $display("FAIL osc_write got %h exp 2a", trim_osc); end
    tests++; if (cmd_done !== 1'b1 || cmd_err !== 1'b0) begin
      fails++; $display("FAIL osc_done got done=%b err=%b exp 1 0", cmd_done, cmd_err);
    end
    tick();
    tests++; if (cmd_done !== 1'b0) begin fails++; $display("FAIL osc_done_pulse got %b exp 0", cmd_done); end
    cs_high();
  endtask

  task automatic test_mux_exit();
    run_frame(8'h03, 8'h05, 1'b0);
    tests++; if (test_mux_sel !== 4'h5) begin fails++; $display("FAIL mux_write got %h exp 5", test_mux_sel); end
    tests++; if (test_disable !== 1'b0) begin fails++; $display("FAIL mux_no_exit got %b exp 0", test_disable); end
    cs_high();
    run_frame(8'h0F, 8'h00, 1'b0);
    tests++; if (test_disable !== 1'b1 || cmd_done !== 1'b1) begin
      fails++; $display("FAIL exit_pulse got dis=%b done=%b exp 1 1", test_disable, cmd_done);
    end
    tick();
    tests++; if (test_disable !== 1'b0) begin fails++; $display("FAIL exit_pulse_end got %b exp 0", test_disable); end
    tests++; if (test_mux_sel !== 4'h5) begin fails++; $display("FAIL mux_held_e17 got %h exp 5", test_mux_sel); end
    test_en = 1'b0;
    tick();
    tests++; if (test_mux_sel !== 4'h0) begin fails++; $display("FAIL mux_clr got %h exp 0", test_mux_sel); end
    tests++; if (trim_osc !== 6'h2A) begin fails++; $display("FAIL osc_held got %h exp 2a", trim_osc); end
    a0_csbar = 1'b1;
    tick();
    test_en = 1'b1;
    tick();
  endtask

  task automatic test_busy();
    run_frame(8'h02, 8'h1F, 1'b1);
    tests++; if (trim_vref !== 5'd16) begin fails++; $display("FAIL busy_vref got %h exp 10", trim_vref); end
    tests++; if (cmd_err !== 1'b1 || cmd_done !== 1'b1) begin
      fails++; $display("FAIL busy_flags got err=%b done=%b exp 1 1", cmd_err, cmd_done);
    end
    cs_high();
    run_frame(8'h02, 8'h1F, 1'b0);
    tests++; if (trim_vref !== 5'h1F) begin fails++; $display("FAIL vref_write got %h exp 1f", trim_vref); end
    tests++; if (cmd_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", cmd_err); end
    cs_high();
    // Clear the sticky error via a test_en drop.
    test_en = 1'b0;
    tick();
    tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL err_clr got %b exp 0", cmd_err); end
    test_en = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    shift_bits(32'h013F, 10);
    cs_high();
    tests++; if (cmd_done !== 1'b0 || trim_osc !== 6'h2A) begin
      fails++; $display("FAIL abort10 got done=%b osc=%h exp 0 2a", cmd_done, trim_osc);
    end
    // CS rising together with the 16th bit aborts as well.
    shift_bits(32'h013F, 15);
    a0_csbar = 1'b1; a2_wpbar = 1'b1;
    tick(); tick();
    tests++; if (cmd_done !== 1'b0 || trim_osc !== 6'h2A) begin
      fails++; $display("FAIL abort16 got done=%b osc=%h exp 0 2a", cmd_done, trim_osc);
    end
    run_frame(8'h01, 8'h07, 1'b0);
    tests++; if (trim_osc !== 6'h07 || cmd_err !== 1'b0) begin
      fails++; $display("FAIL after_abort got osc=%h err=%b exp 07 0", trim_osc, cmd_err);
    end
    cs_high();
    run_frame(8'h55, 8'h03, 1'b0);
    tests++; if (cmd_err !== 1'b1 || cmd_done !== 1'b1) begin
      fails++; $display("FAIL bad_op got err=%b done=%b exp 1 1", cmd_err, cmd_done);
    end
    tests++; if ({trim_osc, trim_vref, test_mux_sel} !== {6'h07, 5'h1F, 4'h0}) begin
      fails++; $display("FAIL bad_op_regs got %h/%h/%h exp 07/1f/0", trim_osc, trim_vref, test_mux_sel);
    end
    cs_high();
  endtask

  task automatic test_extra_bits();
    shift_bits(32'h0111F, 20);
    tests++; if (trim_osc !== 6'h11) begin fails++; $display("FAIL extra_osc got %h exp 11", trim_osc); end
    tests++; if (cmd_done !== 1'b0) begin fails++; $display("FAIL extra_done got %b exp 0", cmd_done); end
    cs_high();
  endtask

  task automatic test_en_drop_exec();
    shift_bits(32'h0115, 16);
    test_en = 1'b0;
    tick();
    tests++; if (trim_osc !== 6'h11 || cmd_done !== 1'b0) begin
      fails++; $display("FAIL en_drop_exec got osc=%h done=%b exp 11 0", trim_osc, cmd_done);
    end
    test_en = 1'b1;
    cs_high();
  endtask

  task automatic test_reset_mid_shift();
    // Leave a sticky error set so reset has something to clear.
    run_frame(8'h77, 8'h00, 1'b0);
    cs_high();
    shift_bits(32'h0103, 9);
    por_rst = 1'b1;
    tick();
    por_rst = 1'b0;
    tests++; if ({trim_osc, trim_vref, test_mux_sel} !== {6'd32, 5'd16, 4'd0}) begin
      fails++; $display("FAIL rst_mid_regs got %h/%h/%h exp 20/10/0", trim_osc, trim_vref, test_mux_sel);
    end
    tests++; if ({test_disable, cmd_done, cmd_err} !== 3'b000) begin
      fails++; $display("FAIL rst_mid_flags got %b exp 000", {test_disable, cmd_done, cmd_err});
    end
    // CS still low: block stays in ARM and ignores this frame.
    shift_bits(32'h013C, 16);
    tick();
    tests++; if (trim_osc !== 6'd32 || cmd_done !== 1'b0) begin
      fails++; $display("FAIL arm_ignore got osc=%h done=%b exp 20 0", trim_osc, cmd_done);
    end
    cs_high();
    run_frame(8'h01, 8'h3C, 1'b0);
    tests++; if (trim_osc !== 6'h3C) begin fails++; $display("FAIL rst_recover got %h exp 3c", trim_osc); end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_trim_osc();
    test_mux_exit();
    test_busy();
    test_abort();
    test_extra_bits();
    test_en_drop_exec();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
